// File: rtl/if_pkg.sv
// Shared types and constants for the WISC instruction-fetch controller.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetchState_t;

  localparam logic [3:0]  OPC_HLT  = 4'hF;
  localparam logic [15:0] PC_RESET = 16'h0000;
  localparam logic [15:0] PC_STEP  = 16'd2;

  function automatic logic isHlt(input logic [15:0] word);
    return (word[15:12] == OPC_HLT);
  endfunction

endpackage

// File: rtl/dff.sv
// Enable flop cell with asynchronous active-low reset to a parameterised value.
module dff #(
  parameter int           W   = 16,
  parameter logic [W-1:0] RST = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl_watchdog.sv
// Fetch watchdog: counts unacknowledged fetch/drain cycles and raises a sticky error.
module fetch_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic countEn,
  input  logic clearEn,
  output logic expire,
  output logic fetchErr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  // Fires on the cycle that would bring the count up to the limit.
  assign expire = countEn && !fetchErr && (count == CNT_W'(TIMEOUT_CYC - 1));

  // Wait counter and sticky error flag; only reset clears the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= {CNT_W{1'b0}};
      fetchErr <= 1'b0;
    end else begin
      if (clearEn) begin
        count <= {CNT_W{1'b0}};
      end else if (countEn) begin
        count <= count + CNT_W'(1);
      end
      if (expire) begin
        fetchErr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// WISC instruction-fetch controller: PC, single-outstanding imem handshake, IF/ID payload.
// Optional fetch watchdog is built when IF_FETCH_WATCHDOG_EN is defined.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic [15:0] instr_o,
  output logic [15:0] pc_plus2_o,
  output logic        instr_valid_o,
  output logic        fetch_halted,
  output logic        fetch_err
);

  fetchState_t state, stateCase, stateNext;

  logic        pcEn, outEn, validEn, validD, holdEn, redirectAct;
  logic [15:0] pcD, pcPlus2, instrD, pcPlus2D, holdInstrD, holdPcD;
  logic [15:0] holdInstr, holdPcPlus2;
  logic        timeoutHit, errSticky;

  assign pcPlus2     = pc + PC_STEP;
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign fetch_halted = (state == HALTED);
  // An error halt is final; a redirect may only leave an HLT halt.
  assign redirectAct = redirect && !((state == HALTED) && errSticky);

`ifdef IF_FETCH_WATCHDOG_EN
  fetch_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) uWatchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .countEn  (((state == FETCH) || (state == DRAIN)) && !imem_ack && !redirect),
    .clearEn  (imem_ack || redirect),
    .expire   (timeoutHit),
    .fetchErr (errSticky)
  );
  assign fetch_err = errSticky;
`else
  assign timeoutHit = 1'b0;
  assign errSticky  = 1'b0;
  assign fetch_err  = (TIMEOUT_CYC > 0) ? 1'b0 : 1'b0;
`endif

  // Next-state and datapath enables; redirect outranks stall, stall outranks ack.
  always_comb begin
    stateCase  = state;
    pcEn       = 1'b0;
    pcD        = pcPlus2;
    outEn      = 1'b0;
    instrD     = imem_rdata;
    pcPlus2D   = pcPlus2;
    validEn    = 1'b0;
    validD     = 1'b0;
    holdEn     = 1'b0;
    holdInstrD = imem_rdata;
    holdPcD    = pcPlus2;

    if (redirectAct) begin
      pcEn       = 1'b1;
      pcD        = redirect_pc;
      validEn    = 1'b1;
      validD     = 1'b0;
      holdEn     = 1'b1;
      holdInstrD = 16'h0000;
      holdPcD    = 16'h0000;
      // A request left in flight must have its ack absorbed before refetching.
      if (((state == FETCH) || (state == DRAIN)) && !imem_ack) begin
        stateCase = DRAIN;
      end else begin
        stateCase = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (stall) begin
            if (imem_ack) begin
              holdEn    = 1'b1;
              pcEn      = 1'b1;
              stateCase = HOLD;
            end else begin
              stateCase = FETCH;
            end
          end else if (imem_ack) begin
            outEn   = 1'b1;
            validEn = 1'b1;
            validD  = 1'b1;
            if (isHlt(imem_rdata)) begin
              stateCase = HALTED;
            end else begin
              pcEn      = 1'b1;
              stateCase = FETCH;
            end
          end else begin
            validEn = 1'b1;
            validD  = 1'b0;
          end
        end
        HOLD: begin
          if (stall) begin
            stateCase = HOLD;
          end else begin
            outEn      = 1'b1;
            instrD     = holdInstr;
            pcPlus2D   = holdPcPlus2;
            validEn    = 1'b1;
            validD     = 1'b1;
            holdEn     = 1'b1;
            holdInstrD = 16'h0000;
            holdPcD    = 16'h0000;
            stateCase  = isHlt(holdInstr) ? HALTED : FETCH;
          end
        end
        DRAIN: begin
          stateCase = imem_ack ? FETCH : DRAIN;
        end
        HALTED: begin
          stateCase = HALTED;
        end
        default: begin
          stateCase = FETCH;
        end
      endcase
    end

    stateNext = timeoutHit ? HALTED : stateCase;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  dff #(.W(16), .RST(PC_RESET)) uPcReg (
    .clk(clk), .rst_n(rst_n), .en(pcEn), .d(pcD), .q(pc)
  );

  dff #(.W(16), .RST(16'h0000)) uInstrReg (
    .clk(clk), .rst_n(rst_n), .en(outEn), .d(instrD), .q(instr_o)
  );

  dff #(.W(16), .RST(16'h0000)) uPcPlus2Reg (
    .clk(clk), .rst_n(rst_n), .en(outEn), .d(pcPlus2D), .q(pc_plus2_o)
  );

  dff #(.W(1), .RST(1'b0)) uValidReg (
    .clk(clk), .rst_n(rst_n), .en(validEn), .d(validD), .q(instr_valid_o)
  );

  dff #(.W(16), .RST(16'h0000)) uHoldInstrReg (
    .clk(clk), .rst_n(rst_n), .en(holdEn), .d(holdInstrD), .q(holdInstr)
  );

  dff #(.W(16), .RST(16'h0000)) uHoldPcReg (
    .clk(clk), .rst_n(rst_n), .en(holdEn), .d(holdPcD), .q(holdPcPlus2)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios, a variable-latency memory,
// and a behavioural model compared against the DUT on every falling edge.
module tb_if_fetch_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] instr_o;
  logic [15:0] pc_plus2_o;
  logic        instr_valid_o;
  logic        fetch_halted;
  logic        fetch_err;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .instr_o(instr_o),
    .pc_plus2_o(pc_plus2_o), .instr_valid_o(instr_valid_o),
    .fetch_halted(fetch_halted), .fetch_err(fetch_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory: one request at a time, fixed latency per request
  logic [15:0] memArr [int];
  int          lat = 0;
  bit          memBusy = 1'b0;
  int          memCnt = 0;
  logic [15:0] memAddr = 16'h0000;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (memArr.exists(int'(a))) return memArr[int'(a)];
    return {4'h1, a[11:0]};
  endfunction

  task automatic memStep();
    imem_ack = 1'b0;
    if (!memBusy && imem_req) begin
      memBusy = 1'b1;
      memCnt  = lat;
      memAddr = imem_addr;
    end
    if (memBusy) begin
      if (memCnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(memAddr);
        memBusy    = 1'b0;
      end else begin
        memCnt--;
      end
    end
  endtask

  // Apply inputs for one cycle, let the memory answer, advance past the edge.
  task automatic cyc(input logic s, input logic r, input logic [15:0] rp);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    memStep();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    memBusy  = 1'b0;
    memArr.delete();
    repeat (2) @(posedge clk);
    #1;
    check16("rst_pc", pc, 16'h0000);
    check16("rst_instr", instr_o, 16'h0000);
    check1("rst_valid", instr_valid_o, 1'b0);
    check1("rst_halted", fetch_halted, 1'b0);
    check1("rst_err", fetch_err, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic expectOut(input string tag, input logic [15:0] ins, input logic [15:0] p2,
                           input logic v, input logic [15:0] pcExp);
    check16({tag, "_instr"}, instr_o, ins);
    check16({tag, "_pc2"}, pc_plus2_o, p2);
    check1({tag, "_valid"}, instr_valid_o, v);
    check16({tag, "_pc"}, pc, pcExp);
  endtask

  // ---------------- behavioural model: where the fetch unit is, not how it is built
  logic [15:0] mPc = 16'h0000, mInstr = 16'h0000, mP2 = 16'h0000;
  logic [15:0] mHeldI = 16'h0000, mHeldP = 16'h0000;
  bit          mValid = 1'b0, mHalted = 1'b0, mHeld = 1'b0, mOrphan = 1'b0, mErr = 1'b0;
  int          mWd = 0;
  wire         mBusy = !mHeld && !mHalted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPc <= 16'h0000; mInstr <= 16'h0000; mP2 <= 16'h0000;
      mHeldI <= 16'h0000; mHeldP <= 16'h0000;
      mValid <= 1'b0; mHalted <= 1'b0; mHeld <= 1'b0; mOrphan <= 1'b0; mErr <= 1'b0;
      mWd <= 0;
    end else begin
      if (mErr) begin
        mPc <= mPc;
      end else if (redirect) begin
        mOrphan <= mBusy && !imem_ack;
        mPc     <= redirect_pc;
        mValid  <= 1'b0;
        mHeld   <= 1'b0;
        mHalted <= 1'b0;
      end else if (mHalted) begin
        mPc <= mPc;
      end else if (mOrphan) begin
        if (imem_ack) mOrphan <= 1'b0;
      end else if (mHeld) begin
        if (!stall) begin
          mInstr <= mHeldI;
          mP2    <= mHeldP;
          mValid <= 1'b1;
          mHeld  <= 1'b0;
          if (mHeldI[15:12] == 4'hF) mHalted <= 1'b1;
        end
      end else if (imem_ack) begin
        if (stall) begin
          mHeld  <= 1'b1;
          mHeldI <= imem_rdata;
          mHeldP <= mPc + 16'd2;
          mPc    <= mPc + 16'd2;
        end else begin
          mInstr <= imem_rdata;
          mP2    <= mPc + 16'd2;
          mValid <= 1'b1;
          if (imem_rdata[15:12] == 4'hF) mHalted <= 1'b1;
          else mPc <= mPc + 16'd2;
        end
      end else if (!stall) begin
        mValid <= 1'b0;
      end
`ifdef IF_FETCH_WATCHDOG_EN
      if (!mErr) begin
        if (imem_ack || redirect) begin
          mWd <= 0;
        end else if (mBusy) begin
          mWd <= mWd + 1;
          if (mWd + 1 == TIMEOUT) begin
            mErr    <= 1'b1;
            mHalted <= 1'b1;
          end
        end
      end
`endif
    end
  end

  // Compare every falling edge.
  always @(negedge clk) begin
    check16("m_pc", pc, mPc);
    check16("m_instr", instr_o, mInstr);
    check16("m_pc2", pc_plus2_o, mP2);
    check1("m_valid", instr_valid_o, mValid);
    check1("m_halted", fetch_halted, mHalted);
    check1("m_req", imem_req, mBusy && !mOrphan);
    check16("m_addr", imem_addr, mPc);
    check1("m_err", fetch_err, mErr);
  end

  initial begin
    // Zero-wait stream ending in HLT.
    doReset();
    lat = 0;
    memArr[0] = 16'h1123; memArr[2] = 16'h2456; memArr[4] = 16'hF000;
    cyc(1'b0, 1'b0, 16'h0000); expectOut("zw0", 16'h1123, 16'h0002, 1'b1, 16'h0002);
    cyc(1'b0, 1'b0, 16'h0000); expectOut("zw1", 16'h2456, 16'h0004, 1'b1, 16'h0004);
    cyc(1'b0, 1'b0, 16'h0000); expectOut("zw2", 16'hF000, 16'h0006, 1'b1, 16'h0004);
    check1("zw_halted", fetch_halted, 1'b1);
    check1("zw_req", imem_req, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000);
    check1("zw_req_after", imem_req, 1'b0);

    // 3-wait memory: one instruction every 4 cycles.
    doReset();
    lat = 3;
    memArr[0] = 16'h1AAA; memArr[2] = 16'h1BBB;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 16'h0000);
      check1("lat_valid", instr_valid_o, (i == 3) || (i == 7));
      check16("lat_pc", pc, 16'(2 * ((i + 1) / 4)));
    end
    check16("lat_instr", instr_o, 16'h1BBB);

    // Ack under stall, held for two cycles.
    doReset();
    lat = 0;
    memArr[0] = 16'h1111; memArr[2] = 16'h1222; memArr[4] = 16'h1333;
    cyc(1'b0, 1'b0, 16'h0000); expectOut("st0", 16'h1111, 16'h0002, 1'b1, 16'h0002);
    cyc(1'b1, 1'b0, 16'h0000); expectOut("st1", 16'h1111, 16'h0002, 1'b1, 16'h0004);
    check1("st1_req", imem_req, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000); expectOut("st2", 16'h1111, 16'h0002, 1'b1, 16'h0004);
    check1("st2_req", imem_req, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000); expectOut("st3", 16'h1222, 16'h0004, 1'b1, 16'h0004);
    check1("st3_req", imem_req, 1'b1);
    cyc(1'b0, 1'b0, 16'h0000); expectOut("st4", 16'h1333, 16'h0006, 1'b1, 16'h0006);

    // Redirect while a 4-wait request is in flight.
    doReset();
    lat = 4;
    memArr[0] = 16'h1ABC; memArr[16'h40] = 16'h1040;
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'h0040);
    check1("dr_req", imem_req, 1'b0);
    check16("dr_pc", pc, 16'h0040);
    lat = 0;
    cyc(1'b0, 1'b0, 16'h0000);
    check1("dr_req2", imem_req, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000);
    expectOut("dr_drop", 16'h0000, 16'h0000, 1'b0, 16'h0040);
    check1("dr_req3", imem_req, 1'b1);
    check16("dr_addr", imem_addr, 16'h0040);
    cyc(1'b0, 1'b0, 16'h0000); expectOut("dr_new", 16'h1040, 16'h0042, 1'b1, 16'h0042);

    // HLT then redirect out of HALTED; redirect with same-cycle ack; PC wrap.
    doReset();
    lat = 0;
    memArr[0] = 16'hF123; memArr[16'h10] = 16'h1010;
    cyc(1'b0, 1'b0, 16'h0000); expectOut("h0", 16'hF123, 16'h0002, 1'b1, 16'h0000);
    check1("h0_halted", fetch_halted, 1'b1);
    cyc(1'b0, 1'b1, 16'h0010);
    check1("h1_halted", fetch_halted, 1'b0);
    check16("h1_addr", imem_addr, 16'h0010);
    check1("h1_valid", instr_valid_o, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000); expectOut("h2", 16'h1010, 16'h0012, 1'b1, 16'h0012);
    cyc(1'b0, 1'b1, 16'hFFFE); expectOut("h3", 16'h1010, 16'h0012, 1'b0, 16'hFFFE);
    check1("h3_req", imem_req, 1'b1);
    cyc(1'b0, 1'b0, 16'h0000); expectOut("wrap", 16'h1FFE, 16'h0000, 1'b1, 16'h0000);

`ifdef IF_FETCH_WATCHDOG_EN
    // Memory never answers: watchdog trips after TIMEOUT cycles and is sticky.
    doReset();
    lat = 1000;
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc(1'b0, 1'b0, 16'h0000);
      check1("wd_err", fetch_err, i == TIMEOUT - 1);
    end
    check1("wd_halted", fetch_halted, 1'b1);
    check1("wd_req", imem_req, 1'b0);
    cyc(1'b0, 1'b1, 16'h0020);
    check1("wd_err_redir", fetch_err, 1'b1);
    check16("wd_pc_redir", pc, 16'h0000);
    doReset();
`endif

    cyc(1'b0, 1'b0, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
